// File: rtl/unpack_pkg.sv
// Shared types and defaults for the word-to-byte unpack engine.
package unpack_pkg;

  localparam int DEF_BYTE_W = 8;
  localparam int DEF_WORDS  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER_HI = 2'd1,
    XFER_LO = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: synchronous write, combinational read, contents not reset.
// One write port and one read port, no stalls.
module ram_sdp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/unpack_fsm.sv
// Splits WORDS input words into 2*WORDS bytes, one byte per cycle (32 cycles start to done_out).
// No backpressure: starts and host writes are dropped while busy; UNPACK_LSB_FIRST_EN puts the low byte at even addresses.
module unpack_fsm
  import unpack_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int WORDS  = DEF_WORDS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ram_in_we,
  input  logic [$clog2(WORDS)-1:0]   ram_in_addr_wr,
  input  logic [2*BYTE_W-1:0]        ram_in_data_wr,
  input  logic [$clog2(2*WORDS)-1:0] ram_out_addr_rd,
  output logic [BYTE_W-1:0]          ram_out_data_rd,
  input  logic                       opmode_in,
  output logic                       done_out
);

  localparam int KW = $clog2(WORDS);

  state_t                state, state_nxt;
  logic [KW-1:0]         k, k_nxt;
  logic                  busy;
  logic [2*BYTE_W-1:0]   word;
  logic [BYTE_W-1:0]     out_byte;
  logic [KW:0]           out_addr;

  assign busy = (state == XFER_HI) || (state == XFER_LO);

  ram_sdp #(.WIDTH(2*BYTE_W), .DEPTH(WORDS)) u_ram_in (
    .clk   (clk),
    .we    (ram_in_we && !busy),
    .waddr (ram_in_addr_wr),
    .wdata (ram_in_data_wr),
    .raddr (k),
    .rdata (word)
  );

  // Reset gates the write so an aborted transfer stops at the reset edge.
  ram_sdp #(.WIDTH(BYTE_W), .DEPTH(2*WORDS)) u_ram_out (
    .clk   (clk),
    .we    (busy && rst_n),
    .waddr (out_addr),
    .wdata (out_byte),
    .raddr (ram_out_addr_rd),
    .rdata (ram_out_data_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    out_addr  = {k, state == XFER_LO};
`ifdef UNPACK_LSB_FIRST_EN
    out_byte  = (state == XFER_HI) ? word[BYTE_W-1:0] : word[2*BYTE_W-1:BYTE_W];
`else
    out_byte  = (state == XFER_HI) ? word[2*BYTE_W-1:BYTE_W] : word[BYTE_W-1:0];
`endif
    case (state)
      IDLE, DONE: begin
        if (opmode_in) begin
          state_nxt = XFER_HI;
          k_nxt     = '0;
        end
      end
      XFER_HI: state_nxt = XFER_LO;
      XFER_LO: begin
        k_nxt     = k + 1'b1;
        state_nxt = (k == KW'(WORDS - 1)) ? DONE : XFER_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done_out = (state == DONE);

endmodule

// File: tb/tb_unpack_fsm.sv
// Directed bench for unpack_fsm with a transaction-level model checked every cycle.
module tb_unpack_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ram_in_we;
  logic [3:0] ram_in_addr_wr;
  logic [15:0] ram_in_data_wr;
  logic [4:0] ram_out_addr_rd;
  logic [7:0] ram_out_data_rd;
  logic       opmode_in;
  logic       done_out;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  unpack_fsm dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ram_in_we       (ram_in_we),
    .ram_in_addr_wr  (ram_in_addr_wr),
    .ram_in_data_wr  (ram_in_data_wr),
    .ram_out_addr_rd (ram_out_addr_rd),
    .ram_out_data_rd (ram_out_data_rd),
    .opmode_in       (opmode_in),
    .done_out        (done_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Model: a transfer is 32 busy edges, edge n writing output byte n from a snapshot of the input RAM.
  logic [15:0] m_in   [16];
  logic [15:0] m_snap [16];
  logic [7:0]  m_out  [32];
  bit          m_val  [32];
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt  = 0;

  function automatic logic [7:0] pick(input logic [15:0] w, input int idx);
`ifdef UNPACK_LSB_FIRST_EN
    return (idx % 2 == 0) ? w[7:0] : w[15:8];
`else
    return (idx % 2 == 0) ? w[15:8] : w[7:0];
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (m_busy) begin
      m_out[m_cnt] = pick(m_snap[m_cnt / 2], m_cnt);
      m_val[m_cnt] = 1'b1;
      m_cnt++;
      if (m_cnt == 32) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      if (ram_in_we) m_in[ram_in_addr_wr] = ram_in_data_wr;
      if (opmode_in) begin
        m_snap = m_in;
        m_busy = 1'b1;
        m_cnt  = 0;
        m_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_done", 32'(done_out), 32'(m_done));
      if (m_val[ram_out_addr_rd])
        check("cyc_read", 32'(ram_out_data_rd), 32'(m_out[ram_out_addr_rd]));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    ram_in_we      = 1'b1;
    ram_in_addr_wr = 4'(a);
    ram_in_data_wr = d;
    tick();
    ram_in_we      = 1'b0;
  endtask

  task automatic start;
    opmode_in = 1'b1;
    tick();
    opmode_in = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done_out !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  // Word pattern loaded by each scenario, straight from the test descriptions.
  function automatic logic [15:0] pat(input int mode, input int k);
    case (mode)
      0:       return {8'(k), 8'h80 | 8'(k)};
      1:       return 16'hA500 + 16'(k);
      default: return {8'h40 + 8'(k), 8'hC0 + 8'(k)};
    endcase
  endfunction

  task automatic sweep(input string name, input int mode);
    for (int a = 0; a < 32; a++) begin
      ram_out_addr_rd = 5'(a);
      #1;
      check(name, 32'(ram_out_data_rd), 32'(pick(pat(mode, a / 2), a)));
      tick();
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    ram_in_we = 1'b0;
    ram_in_addr_wr = '0;
    ram_in_data_wr = '0;
    ram_out_addr_rd = '0;
    opmode_in = 1'b0;
    repeat (10) tick();
    check("reset_done", 32'(done_out), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();
    check("idle_done", 32'(done_out), 32'd0);

    // Basic transfer and latency
    for (int k = 0; k < 16; k++) wr(k, pat(0, k));
    start();
    wait_done(cyc);
    check("latency_basic", 32'(cyc), 32'd32);
`ifdef UNPACK_LSB_FIRST_EN
    check("pin_model_5", 32'(m_out[5]), 32'h02);
    check("pin_model_4", 32'(m_out[4]), 32'h82);
`else
    check("pin_model_5", 32'(m_out[5]), 32'h82);
    check("pin_model_4", 32'(m_out[4]), 32'h02);
`endif
    sweep("basic_rd", 0);

    // Re-run from DONE
    for (int k = 0; k < 16; k++) wr(k, pat(1, k));
    check("done_hold", 32'(done_out), 32'd1);
    start();
    check("done_fall", 32'(done_out), 32'd0);
    wait_done(cyc);
    check("latency_rerun", 32'(cyc), 32'd32);
    sweep("rerun_rd", 1);

    // Busy-time write and start are dropped
    ram_out_addr_rd = 5'd30;
    start();
    repeat (4) tick();
    ram_in_we = 1'b1;
    ram_in_addr_wr = 4'd15;
    ram_in_data_wr = 16'hFFFF;
    opmode_in = 1'b1;
    tick();
    ram_in_we = 1'b0;
    opmode_in = 1'b0;
    wait_done(cyc);
    check("latency_busy", 32'(cyc + 5), 32'd32);
    check("pin_model_in15", 32'(m_in[15]), 32'hA50F);
`ifdef UNPACK_LSB_FIRST_EN
    #1 check("busy_rd30", 32'(ram_out_data_rd), 32'h0F);
    ram_out_addr_rd = 5'd31;
    #1 check("busy_rd31", 32'(ram_out_data_rd), 32'hA5);
`else
    #1 check("busy_rd30", 32'(ram_out_data_rd), 32'hA5);
    ram_out_addr_rd = 5'd31;
    #1 check("busy_rd31", 32'(ram_out_data_rd), 32'h0F);
`endif
    tick();
    sweep("busy_rd", 1);

    // Reset mid-transfer, then a clean transfer
    for (int k = 0; k < 16; k++) wr(k, pat(2, k));
    start();
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_done", 32'(done_out), 32'd0);
    repeat (40) tick();
    check("abort_idle", 32'(done_out), 32'd0);
    start();
    wait_done(cyc);
    check("latency_after_rst", 32'(cyc), 32'd32);
    sweep("after_rst_rd", 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
